// File: rtl/vx_fpu_pe_gather_pkg.sv
// Shared types and helpers for the FPU per-PE result gather block.
// Lane-count and batch helpers plus the masked fflags merge.
package vx_fpu_pe_gather_pkg;

  localparam int FP_FLAGS_BITS = 5;
  localparam int MAX_LANES     = 64;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int gather_batches(input int num_lanes, input int num_pes);
    return (num_lanes + num_pes - 1) / num_pes;
  endfunction

  function automatic int gather_cnt_width(input int batches);
    return (batches > 1) ? $clog2(batches) : 1;
  endfunction

  // Lanes beyond the real lane count must arrive with their mask bit cleared.
  function automatic fflags_t merge_fflags(
    input logic [MAX_LANES*FP_FLAGS_BITS-1:0] lane_flags,
    input logic [MAX_LANES-1:0]               lane_mask
  );
    logic [FP_FLAGS_BITS-1:0] acc;
    acc = {FP_FLAGS_BITS{1'b0}};
    for (int i = 0; i < MAX_LANES; i++) begin
      if (lane_mask[i]) begin
        acc = acc | lane_flags[i*FP_FLAGS_BITS +: FP_FLAGS_BITS];
      end else begin
        acc = acc;
      end
    end
    return fflags_t'(acc);
  endfunction

endpackage

// File: rtl/vx_fpu_pe_gather_buf.sv
// Fill buffer for vx_fpu_pe_gather: one slot per lane with a lane-indexed
// write enable. Flag storage exists only when FPU_GATHER_FFLAGS_EN is defined.
module vx_fpu_pe_gather_buf
  import vx_fpu_pe_gather_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int NUM_PES   = 2,
  parameter int CNT_W     = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [CNT_W-1:0]                   batch_idx,
  input  logic [NUM_PES*32-1:0]              pe_data,
  input  logic [NUM_PES*FP_FLAGS_BITS-1:0]   pe_fflags,
  output logic [NUM_LANES*32-1:0]            merged_data,
  output logic [NUM_LANES*FP_FLAGS_BITS-1:0] merged_fflags
);

  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    localparam int               PE    = lane % NUM_PES;
    localparam logic [CNT_W-1:0] BATCH = CNT_W'(lane / NUM_PES);

    logic        we_s;
    logic [31:0] data_r;

    assign we_s = wr_en && (batch_idx == BATCH);

    // lane data slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_r <= 32'd0;
      end else if (we_s) begin
        data_r <= pe_data[PE*32 +: 32];
      end
    end

    // The beat being written bypasses its slot so the final beat can complete in one cycle.
    assign merged_data[lane*32 +: 32] = we_s ? pe_data[PE*32 +: 32] : data_r;

`ifdef FPU_GATHER_FFLAGS_EN
    logic [FP_FLAGS_BITS-1:0] flags_r;

    // lane flag slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        flags_r <= {FP_FLAGS_BITS{1'b0}};
      end else if (we_s) begin
        flags_r <= pe_fflags[PE*FP_FLAGS_BITS +: FP_FLAGS_BITS];
      end
    end

    assign merged_fflags[lane*FP_FLAGS_BITS +: FP_FLAGS_BITS] =
      we_s ? pe_fflags[PE*FP_FLAGS_BITS +: FP_FLAGS_BITS] : flags_r;
`else
    assign merged_fflags[lane*FP_FLAGS_BITS +: FP_FLAGS_BITS] = {FP_FLAGS_BITS{1'b0}};
`endif
  end

`ifndef FPU_GATHER_FFLAGS_EN
  logic unused_fflags_s;
  assign unused_fflags_s = ^pe_fflags;
`endif

endmodule

// File: rtl/vx_fpu_pe_gather_chk.sv
// Simulation checker for vx_fpu_pe_gather: the tag must not change between
// the beats of one vector. Tracks beats from the port-level handshake.
module vx_fpu_pe_gather_chk #(
  parameter int BATCHES   = 3,
  parameter int TAG_WIDTH = 1
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 valid_in,
  input logic                 ready_in,
  input logic [TAG_WIDTH-1:0] tag_in
);

  int                   beat_r;
  logic [TAG_WIDTH-1:0] tag_r;

  // beat tracker and first-beat tag capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_r <= 32'sd0;
      tag_r  <= {TAG_WIDTH{1'b0}};
    end else if (valid_in && ready_in) begin
      beat_r <= (beat_r == BATCHES - 1) ? 32'sd0 : beat_r + 32'sd1;
      if (beat_r == 32'sd0) begin
        tag_r <= tag_in;
      end
    end
  end

  tag_stable: assert property (@(posedge clk) disable iff (reset)
    (valid_in && ready_in && beat_r != 32'sd0) |-> (tag_in == tag_r));

endmodule

// File: rtl/vx_fpu_pe_gather.sv
// Gathers per-PE FPU result beats into a full lane vector behind a registered
// valid/ready output. Optional flag merging: FPU_GATHER_FFLAGS_EN.
module vx_fpu_pe_gather
  import vx_fpu_pe_gather_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int NUM_PES   = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [NUM_PES*32-1:0]            pe_data_in,
  input  logic [NUM_PES*FP_FLAGS_BITS-1:0] pe_fflags_in,
  input  logic [NUM_LANES-1:0]             mask_in,
  input  logic [TAG_WIDTH-1:0]             tag_in,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [NUM_LANES*32-1:0]          result,
  output logic [FP_FLAGS_BITS-1:0]         fflags,
  output logic                             has_fflags,
  output logic [NUM_LANES-1:0]             mask_out,
  output logic [TAG_WIDTH-1:0]             tag_out
);

  localparam int               BATCHES     = gather_batches(NUM_LANES, NUM_PES);
  localparam int               CNT_W       = gather_cnt_width(BATCHES);
  localparam int               FLAGS_PAD_W = MAX_LANES * FP_FLAGS_BITS;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(BATCHES - 1);

  logic [CNT_W-1:0]                   batch_cnt_r;
  logic [NUM_LANES-1:0]               mask_r;
  logic [TAG_WIDTH-1:0]               tag_r;
  logic                               is_last_s;
  logic                               is_first_s;
  logic                               fire_s;
  logic                               load_s;
  logic [NUM_LANES-1:0]               mask_sel_s;
  logic [TAG_WIDTH-1:0]               tag_sel_s;
  logic [NUM_LANES*32-1:0]            merged_data_s;
  logic [NUM_LANES*FP_FLAGS_BITS-1:0] merged_fflags_s;
  logic [FP_FLAGS_BITS-1:0]           fflags_next_s;

`ifdef FPU_GATHER_FFLAGS_EN
  assign has_fflags = 1'b1;
`else
  assign has_fflags = 1'b0;
`endif

  // handshake decode; only the completing beat sees back-pressure
  always_comb begin
    is_last_s  = (batch_cnt_r == LAST_CNT);
    is_first_s = (batch_cnt_r == {CNT_W{1'b0}});
    ready_in   = !(valid_out && !ready_out && is_last_s);
    fire_s     = valid_in && ready_in;
    load_s     = fire_s && is_last_s;
    if (is_first_s) begin
      mask_sel_s = mask_in;
      tag_sel_s  = tag_in;
    end else begin
      mask_sel_s = mask_r;
      tag_sel_s  = tag_r;
    end
  end

  vx_fpu_pe_gather_buf #(
    .NUM_LANES (NUM_LANES),
    .NUM_PES   (NUM_PES),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (fire_s),
    .batch_idx     (batch_cnt_r),
    .pe_data       (pe_data_in),
    .pe_fflags     (pe_fflags_in),
    .merged_data   (merged_data_s),
    .merged_fflags (merged_fflags_s)
  );

  // Flag slots are all zero without flag storage, so the merge yields zero there.
  assign fflags_next_s = merge_fflags(FLAGS_PAD_W'(merged_fflags_s), MAX_LANES'(mask_sel_s));

  // beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      batch_cnt_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      batch_cnt_r <= is_last_s ? {CNT_W{1'b0}} : batch_cnt_r + CNT_W'(1);
    end
  end

  // first-beat mask and tag capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r <= {NUM_LANES{1'b0}};
      tag_r  <= {TAG_WIDTH{1'b0}};
    end else if (fire_s && is_first_s) begin
      mask_r <= mask_in;
      tag_r  <= tag_in;
    end
  end

  // output register; a completing beat wins over a drain in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      result    <= {(NUM_LANES*32){1'b0}};
      fflags    <= {FP_FLAGS_BITS{1'b0}};
      mask_out  <= {NUM_LANES{1'b0}};
      tag_out   <= {TAG_WIDTH{1'b0}};
    end else if (load_s) begin
      valid_out <= 1'b1;
      result    <= merged_data_s;
      fflags    <= fflags_next_s;
      mask_out  <= mask_sel_s;
      tag_out   <= tag_sel_s;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_fpu_pe_gather.sv
// Directed self-checking bench for vx_fpu_pe_gather (5 lanes/2 PEs and 4 lanes/4 PEs).
module tb_vx_fpu_pe_gather;
  import vx_fpu_pe_gather_pkg::*;

`ifdef FPU_GATHER_FFLAGS_EN
  localparam logic [4:0] NX_EXP  = 5'b00001;
  localparam logic [4:0] DZ_EXP  = 5'b01000;
  localparam logic       HAS_EXP = 1'b1;
`else
  localparam logic [4:0] NX_EXP  = 5'b00000;
  localparam logic [4:0] DZ_EXP  = 5'b00000;
  localparam logic       HAS_EXP = 1'b0;
`endif

  localparam logic [159:0] EXP_A   = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [159:0] EXP_B   = {32'd25, 32'd24, 32'd23, 32'd22, 32'd21};
  localparam logic [159:0] EXP_RST = {32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
  localparam logic [4:0]   NX      = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         valid_in, ready_in, valid_out, ready_out, has_fflags;
  logic [63:0]  pe_data_in;
  logic [9:0]   pe_fflags_in;
  logic [4:0]   mask_in, mask_out, fflags;
  logic [0:0]   tag_in, tag_out;
  logic [159:0] result;

  logic         v4_valid_in, v4_ready_in, v4_valid_out, v4_ready_out, v4_has_fflags;
  logic [127:0] v4_data_in, v4_result;
  logic [19:0]  v4_fflags_in;
  logic [3:0]   v4_mask_in, v4_mask_out;
  logic [4:0]   v4_fflags;
  logic [0:0]   v4_tag_in, v4_tag_out;

  int n_checks = 0;
  int n_fail   = 0;

  vx_fpu_pe_gather #(.NUM_LANES(5), .NUM_PES(2), .TAG_WIDTH(1)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .pe_data_in(pe_data_in), .pe_fflags_in(pe_fflags_in), .mask_in(mask_in),
    .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out), .result(result),
    .fflags(fflags), .has_fflags(has_fflags), .mask_out(mask_out), .tag_out(tag_out)
  );

  vx_fpu_pe_gather #(.NUM_LANES(4), .NUM_PES(4), .TAG_WIDTH(1)) u_dut4 (
    .clk(clk), .reset(reset), .valid_in(v4_valid_in), .ready_in(v4_ready_in),
    .pe_data_in(v4_data_in), .pe_fflags_in(v4_fflags_in), .mask_in(v4_mask_in),
    .tag_in(v4_tag_in), .valid_out(v4_valid_out), .ready_out(v4_ready_out), .result(v4_result),
    .fflags(v4_fflags), .has_fflags(v4_has_fflags), .mask_out(v4_mask_out), .tag_out(v4_tag_out)
  );

  vx_fpu_pe_gather_chk #(.BATCHES(3), .TAG_WIDTH(1)) u_chk (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in)
  );

  vx_fpu_pe_gather_chk #(.BATCHES(1), .TAG_WIDTH(1)) u_chk4 (
    .clk(clk), .reset(reset), .valid_in(v4_valid_in), .ready_in(v4_ready_in), .tag_in(v4_tag_in)
  );

  // Present one beat and return #1 after the edge that accepted it.
  task automatic beat(input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] f0,
                      input logic [4:0] f1, input logic [4:0] m, input logic t);
    int guard;
    guard        = 0;
    pe_data_in   = {d1, d0};
    pe_fflags_in = {f1, f0};
    mask_in      = m;
    tag_in       = t;
    valid_in     = 1'b1;
    while (ready_in !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: ready_in=%b, required 1", ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", valid_out); end
    n_checks++; if (result !== 160'd0) begin n_fail++; $display("FAIL rst_result: got %h, required 0", result); end
    n_checks++; if ({fflags, mask_out, tag_out} !== 11'd0) begin n_fail++; $display("FAIL rst_side: got %h, required 0", {fflags, mask_out, tag_out}); end
    n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", ready_in); end
    n_checks++; if (v4_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_v4_valid: got %b, required 0", v4_valid_out); end
    n_checks++; if ({has_fflags, v4_has_fflags} !== {HAS_EXP, HAS_EXP}) begin n_fail++; $display("FAIL has_fflags: got %b, required %b", {has_fflags, v4_has_fflags}, {HAS_EXP, HAS_EXP}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    ready_out = 1'b1;
    beat(32'd1, 32'd2, 5'd0, 5'd0, 5'b11111, 1'b1);
    beat(32'd3, 32'd4, 5'd0, 5'd0, 5'b11111, 1'b1);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", valid_out); end
    beat(32'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'b11111, 1'b1);
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, required 1", valid_out); end
    n_checks++; if (result !== EXP_A) begin n_fail++; $display("FAIL basic_result: got %h, required %h", result, EXP_A); end
    n_checks++; if ({tag_out, mask_out} !== {1'b1, 5'b11111}) begin n_fail++; $display("FAIL basic_tag_mask: got %b, required %b", {tag_out, mask_out}, {1'b1, 5'b11111}); end
    @(posedge clk); #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b, required 0", valid_out); end
  endtask

  task automatic test_fflags();
    beat(32'd10, 32'd11, 5'd0, 5'd0, 5'b10111, 1'b0);
    beat(32'd12, 32'd13, 5'd0, NX,   5'b10111, 1'b0);
    beat(32'd14, 32'd0,  5'd0, 5'd0, 5'b10111, 1'b0);
    n_checks++; if (fflags !== 5'b00000) begin n_fail++; $display("FAIL ff_masked: got %b, required 00000", fflags); end
    n_checks++; if (result[127:96] !== 32'd13) begin n_fail++; $display("FAIL ff_lane3_data: got %0d, required 13", result[127:96]); end
    n_checks++; if ({tag_out, mask_out} !== {1'b0, 5'b10111}) begin n_fail++; $display("FAIL ff_tag_mask: got %b, required %b", {tag_out, mask_out}, {1'b0, 5'b10111}); end
    beat(32'd10, 32'd11, 5'd0, 5'd0, 5'b11111, 1'b1);
    beat(32'd12, 32'd13, 5'd0, NX,   5'b11111, 1'b1);
    beat(32'd14, 32'd0,  5'd0, 5'd0, 5'b11111, 1'b1);
    n_checks++; if (fflags !== NX_EXP) begin n_fail++; $display("FAIL ff_unmasked: got %b, required %b", fflags, NX_EXP); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    ready_out = 1'b1;
    beat(32'd1, 32'd2, 5'd0, 5'd0, 5'b11111, 1'b1);
    beat(32'd3, 32'd4, 5'd0, 5'd0, 5'b11111, 1'b1);
    beat(32'd5, 32'd9, 5'd0, 5'd0, 5'b11111, 1'b1);
    ready_out = 1'b0;
    beat(32'd21, 32'd22, 5'd0, 5'd0, 5'b11111, 1'b0);
    beat(32'd23, 32'd24, 5'd0, 5'd0, 5'b11111, 1'b0);
    pe_data_in = {32'd26, 32'd25};
    valid_in   = 1'b1;
    #1;
    n_checks++; if (ready_in !== 1'b0) begin n_fail++; $display("FAIL stall_ready_low: got %b, required 0", ready_in); end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if ({valid_out, result} !== {1'b1, EXP_A}) begin n_fail++; $display("FAIL stall_hold: got %b/%h, required 1/%h", valid_out, result, EXP_A); end
    ready_out = 1'b1;
    #1;
    n_checks++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL stall_ready_release: got %b, required 1", ready_in); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    n_checks++; if ({valid_out, tag_out, result} !== {1'b1, 1'b0, EXP_B}) begin n_fail++; $display("FAIL stall_b2b: got %b/%b/%h, required 1/0/%h", valid_out, tag_out, result, EXP_B); end
    @(posedge clk); #1;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b, required 0", valid_out); end
  endtask

  task automatic test_reset_mid();
    beat(32'd31, 32'd32, 5'd0, 5'd0, 5'b11111, 1'b1);
    beat(32'd33, 32'd34, 5'd0, 5'd0, 5'b11111, 1'b1);
    reset = 1'b1;
    #1;
    n_checks++; if ({valid_out, ready_in} !== 2'b01) begin n_fail++; $display("FAIL mid_rst_hs: got %b, required 01", {valid_out, ready_in}); end
    n_checks++; if (result !== 160'd0) begin n_fail++; $display("FAIL mid_rst_result: got %h, required 0", result); end
    @(posedge clk); #1;
    reset = 1'b0;
    beat(32'd9, 32'd8, 5'd0, 5'd0, 5'b11111, 1'b0);
    beat(32'd7, 32'd6, 5'd0, 5'd0, 5'b11111, 1'b0);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_early: got %b, required 0", valid_out); end
    beat(32'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'b11111, 1'b0);
    n_checks++; if ({valid_out, result} !== {1'b1, EXP_RST}) begin n_fail++; $display("FAIL mid_rst_result2: got %b/%h, required 1/%h", valid_out, result, EXP_RST); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_batch();
    logic [127:0] d [3];
    d[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    d[1] = {32'd40, 32'd30, 32'd20, 32'd10};
    d[2] = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    v4_ready_out = 1'b1;
    v4_mask_in   = 4'b1011;
    v4_tag_in    = 1'b1;
    v4_valid_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v4_data_in   = d[i];
      v4_fflags_in = (i == 2) ? {5'b01000, NX, 10'd0} : 20'd0;
      #1;
      n_checks++; if (v4_ready_in !== 1'b1) begin n_fail++; $display("FAIL pe4_ready[%0d]: got %b, required 1", i, v4_ready_in); end
      @(posedge clk); #1;
      n_checks++; if ({v4_valid_out, v4_result} !== {1'b1, d[i]}) begin n_fail++; $display("FAIL pe4_vec[%0d]: got %b/%h, required 1/%h", i, v4_valid_out, v4_result, d[i]); end
    end
    n_checks++; if ({v4_fflags, v4_mask_out, v4_tag_out} !== {DZ_EXP, 4'b1011, 1'b1}) begin n_fail++; $display("FAIL pe4_side: got %b, required %b", {v4_fflags, v4_mask_out, v4_tag_out}, {DZ_EXP, 4'b1011, 1'b1}); end
    v4_valid_in = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (v4_valid_out !== 1'b0) begin n_fail++; $display("FAIL pe4_drain: got %b, required 0", v4_valid_out); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    valid_in     = 1'b0;
    ready_out    = 1'b1;
    pe_data_in   = 64'd0;
    pe_fflags_in = 10'd0;
    mask_in      = 5'd0;
    tag_in       = 1'b0;
    v4_valid_in  = 1'b0;
    v4_ready_out = 1'b1;
    v4_data_in   = 128'd0;
    v4_fflags_in = 20'd0;
    v4_mask_in   = 4'd0;
    v4_tag_in    = 1'b0;
    test_reset();
    test_basic();
    test_fflags();
    test_stall();
    test_reset_mid();
    test_single_batch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
